// File: rtl/data_memory_controller.sv
// data_memory_controller: two-port arbiter/sequencer for the latch-based data memory; define DMEM_CTRL_RR_EN for round-robin arbitration (fixed CPU priority otherwise).
module data_memory_controller #(
   parameter int D_ADDR_W = 12,
   parameter int DATA_W   = 8
) (
   input  logic                clk,
   input  logic                rst_n,
   input  logic                cpu_req_valid,
   output logic                cpu_req_ready,
   input  logic                cpu_req_write,
   input  logic [D_ADDR_W-1:0] cpu_req_addr,
   input  logic [DATA_W-1:0]   cpu_req_wdata,
   output logic                cpu_rsp_valid,
   output logic [DATA_W-1:0]   cpu_rsp_rdata,
   input  logic                dbg_req_valid,
   output logic                dbg_req_ready,
   input  logic                dbg_req_write,
   input  logic [D_ADDR_W-1:0] dbg_req_addr,
   input  logic [DATA_W-1:0]   dbg_req_wdata,
   output logic                dbg_rsp_valid,
   output logic [DATA_W-1:0]   dbg_rsp_rdata,
   output logic [D_ADDR_W-1:0] mem_addr,
   output logic [DATA_W-1:0]   mem_wdata,
   output logic                mem_we,
   output logic                mem_oe,
   input  logic [DATA_W-1:0]   mem_rdata
);
   typedef enum logic [2:0] {IDLE, READ, WR_SETUP, WR_PULSE, WR_HOLD} state_t;
   state_t state;
   logic gnt_dbg;
   logic pick_dbg;
   logic idle_ok;
   logic req_write;
   logic [D_ADDR_W-1:0] req_addr;
   logic [DATA_W-1:0] req_wdata;
`ifdef DMEM_CTRL_RR_EN
   logic last_dbg;
   assign pick_dbg = dbg_req_valid & (~cpu_req_valid | ~last_dbg);
`else
   assign pick_dbg = dbg_req_valid & ~cpu_req_valid;
`endif
   assign idle_ok       = rst_n & (state == IDLE);
   assign cpu_req_ready = idle_ok & cpu_req_valid & ~pick_dbg;
   assign dbg_req_ready = idle_ok & pick_dbg;
   assign req_write     = pick_dbg ? dbg_req_write : cpu_req_write;
   assign req_addr      = pick_dbg ? dbg_req_addr : cpu_req_addr;
   assign req_wdata     = pick_dbg ? dbg_req_wdata : cpu_req_wdata;
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state         <= IDLE;
         gnt_dbg       <= 1'b0;
         mem_addr      <= '0;
         mem_wdata     <= '0;
         mem_we        <= 1'b0;
         mem_oe        <= 1'b0;
         cpu_rsp_valid <= 1'b0;
         dbg_rsp_valid <= 1'b0;
         cpu_rsp_rdata <= '0;
         dbg_rsp_rdata <= '0;
`ifdef DMEM_CTRL_RR_EN
         last_dbg      <= 1'b1;
`endif
      end else begin
         cpu_rsp_valid <= 1'b0;
         dbg_rsp_valid <= 1'b0;
         case (state)
            IDLE: if (cpu_req_ready | dbg_req_ready) begin
               gnt_dbg  <= pick_dbg;
               mem_addr <= req_addr;
`ifdef DMEM_CTRL_RR_EN
               last_dbg <= pick_dbg;
`endif
               if (req_write) begin
                  mem_wdata <= req_wdata;
                  state     <= WR_SETUP;
               end else begin
                  mem_oe <= 1'b1;
                  state  <= READ;
               end
            end
            READ: begin
               mem_oe <= 1'b0;
               if (gnt_dbg) dbg_rsp_rdata <= mem_rdata;
               else cpu_rsp_rdata <= mem_rdata;
               dbg_rsp_valid <= gnt_dbg;
               cpu_rsp_valid <= ~gnt_dbg;
               state         <= IDLE;
            end
            // address and data were settled during SETUP, so we pulses over a stable bus
            WR_SETUP: begin
               mem_we <= 1'b1;
               state  <= WR_PULSE;
            end
            WR_PULSE: begin
               mem_we <= 1'b0;
               state  <= WR_HOLD;
            end
            WR_HOLD: begin
               dbg_rsp_valid <= gnt_dbg;
               cpu_rsp_valid <= ~gnt_dbg;
               state         <= IDLE;
            end
            default: state <= IDLE;
         endcase
      end
   end
endmodule
